// File: rtl/stage_fetch_pkg.sv
// Shared constants and payload types for the fetch stage and its instruction queue.
package stage_fetch_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_2000;

    localparam logic [1:0] PC_SEL_PLUS4  = 2'b00;
    localparam logic [1:0] PC_SEL_JUMP   = 2'b01;
    localparam logic [1:0] PC_SEL_BRANCH = 2'b10;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/stage_fetch_fetch_buffer.sv
// In-order instruction queue holding {pc, instr} pairs; flush wins over push.
module fetch_buffer
    import stage_fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 2
)(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  fetch_entry_t           push_data,
    input  logic                   pop,
    input  logic                   flush,
    output fetch_entry_t           head,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    fetch_entry_t    mem [DEPTH];
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Storage needs no reset: count gates every read.
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= push_data;
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/stage_fetch.sv
// Fetch stage: issues imem requests under a credit limit, queues responses, handles redirects.
// Optional FETCH_PERF_CNT_EN adds bubble/redirect performance counters.
module stage_fetch
    import stage_fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter int unsigned     BUF_DEPTH = 2
)(
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_resp_valid,
    input  logic [XLEN-1:0] imem_resp_data,
    input  logic            stallD,
    input  logic [1:0]      pc_selD,
    input  logic [XLEN-1:0] branch_targetD,
    input  logic [XLEN-1:0] jump_targetD,
    output logic [XLEN-1:0] instrD,
    output logic [XLEN-1:0] pcD,
    output logic            validD
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]     perf_bubbles,
    output logic [31:0]     perf_redirects
`endif
);

    localparam int unsigned CW = $clog2(BUF_DEPTH) + 1;
    localparam int unsigned OW = CW + 1;

    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] resp_pc;
    logic [XLEN-1:0] target;
    logic [CW-1:0]   outst;
    logic [CW-1:0]   drop_cnt;
    logic [CW-1:0]   count;
    logic [OW-1:0]   occupancy;
    logic            redir;
    logic            issue_hs;
    logic            resp_accept;
    logic            push;
    logic            pop;
    fetch_entry_t    head;
    fetch_entry_t    push_data;

    assign validD    = (count != '0);
    assign pop       = validD && !stallD;
    assign redir     = pop && (pc_selD != PC_SEL_PLUS4);
    assign target    = align_word((pc_selD == PC_SEL_BRANCH) ? branch_targetD : jump_targetD);
    assign occupancy = OW'(outst) + OW'(count);

    // Request valid depends only on registered credit state and redirect, never on ready.
    assign imem_req_valid = rst && (occupancy < OW'(BUF_DEPTH)) && !redir;
    assign imem_req_addr  = fetch_pc;
    assign issue_hs       = imem_req_valid && imem_req_ready;

    assign resp_accept = imem_resp_valid && (outst != '0);
    assign push        = resp_accept && (drop_cnt == '0);
    assign push_data   = '{pc: resp_pc, instr: imem_resp_data};

    assign instrD = validD ? head.instr : NOP_INSTR;
    assign pcD    = validD ? head.pc : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc <= RESET_PC;
            resp_pc  <= RESET_PC;
            outst    <= '0;
            drop_cnt <= '0;
        end else begin
            outst <= outst + CW'(issue_hs) - CW'(resp_accept);
            if (redir) begin
                fetch_pc <= target;
                resp_pc  <= target;
                drop_cnt <= outst + drop_cnt - CW'(resp_accept);
            end else begin
                if (issue_hs) fetch_pc <= fetch_pc + XLEN'(4);
                if (resp_accept) begin
                    if (drop_cnt != '0) drop_cnt <= drop_cnt - CW'(1);
                    else                resp_pc  <= resp_pc + XLEN'(4);
                end
            end
        end
    end

    fetch_buffer #(
        .DEPTH (BUF_DEPTH)
    ) u_fetch_buffer (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .flush     (redir),
        .head      (head),
        .count     (count)
    );

`ifdef FETCH_PERF_CNT_EN
    // Saturating event counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_bubbles   <= '0;
            perf_redirects <= '0;
        end else begin
            if (!validD && !stallD && (perf_bubbles != '1))
                perf_bubbles <= perf_bubbles + 32'd1;
            if (redir && (perf_redirects != '1))
                perf_redirects <= perf_redirects + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_stage_fetch.sv
// Scoreboard bench for stage_fetch with a 1-cycle instruction memory returning addr ^ KEY.
module tb_stage_fetch;
    import stage_fetch_pkg::*;

    localparam logic [31:0] KEY = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        stallD;
    logic [1:0]  pc_selD;
    logic [31:0] branch_targetD;
    logic [31:0] jump_targetD;
    logic [31:0] instrD;
    logic [31:0] pcD;
    logic        validD;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_bubbles;
    logic [31:0] perf_redirects;
`endif

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    stage_fetch dut (
        .clk             (clk),
        .rst             (rst),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .stallD          (stallD),
        .pc_selD         (pc_selD),
        .branch_targetD  (branch_targetD),
        .jump_targetD    (jump_targetD),
        .instrD          (instrD),
        .pcD             (pcD),
        .validD          (validD)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_bubbles    (perf_bubbles),
        .perf_redirects  (perf_redirects)
`endif
    );

    // Memory model, reset together with the DUT
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            imem_resp_valid <= 1'b0;
            imem_resp_data  <= '0;
        end else begin
            imem_resp_valid <= imem_req_valid && imem_req_ready;
            imem_resp_data  <= imem_req_addr ^ KEY;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // Monitor: every consumed instruction must match the scoreboard head
    initial begin
        logic [31:0] e;
        forever begin
            @(negedge clk);
            if (rst && validD && !stallD) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL sb_unexpected: got pc %h, required no instruction", pcD);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_pc", pcD, e);
                    check("sb_instr", instrD, e ^ KEY);
                end
            end else if (rst && !validD) begin
                check("idle_nop", instrD, NOP_INSTR);
            end
        end
    end

    task automatic push_seq(input logic [31:0] start, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(start + 32'(4 * i));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_pc(input logic [31:0] pc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            step();
            if (validD && pcD == pc) ok = 1'b1;
        end
        if (!ok) begin
            n_checks++;
            n_errors++;
            $display("FAIL wait_pc: got pcD %h, required %h within 200 cycles", pcD, pc);
        end
    endtask

    task automatic redirect_at(input logic [31:0] pc, input logic [1:0] sel,
                               input logic [31:0] jt, input logic [31:0] bt);
        bit ok;
        wait_pc(pc, ok);
        if (ok) begin
            pc_selD        = sel;
            jump_targetD   = jt;
            branch_targetD = bt;
            step();
            pc_selD = PC_SEL_PLUS4;
        end
    endtask

    initial begin
        bit ok;
        imem_req_ready = 1'b1;
        stallD         = 1'b0;
        pc_selD        = PC_SEL_PLUS4;
        branch_targetD = '0;
        jump_targetD   = '0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_validD", 32'(validD), 32'd0);
        check("rst_instrD", instrD, NOP_INSTR);
        check("rst_pcD", pcD, 32'd0);
        check("rst_req_valid", 32'(imem_req_valid), 32'd0);

        // Reset release and first-fetch latency
        @(negedge clk);
        rst = 1'b1;
        push_seq(32'h0000_2000, 5);
        #1;
        check("first_req_valid", 32'(imem_req_valid), 32'd1);
        check("first_req_addr", imem_req_addr, 32'h0000_2000);
        step();
        check("lat_c1_validD", 32'(validD), 32'd0);
        step();
        check("lat_c2_validD", 32'(validD), 32'd1);
        check("lat_c2_pcD", pcD, 32'h0000_2000);

        // Stall with the queue filling up
        wait_pc(32'h0000_2008, ok);
        stallD = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            check("stall_pcD", pcD, 32'h0000_2008);
            check("stall_instrD", instrD, 32'h0000_2008 ^ KEY);
            if (k >= 2) check("stall_req_valid", 32'(imem_req_valid), 32'd0);
        end
        stallD = 1'b0;

        // Jump at 0x2010 to 0x3000
        push_seq(32'h0000_3000, 3);
        redirect_at(32'h0000_2010, PC_SEL_JUMP, 32'h0000_3000, 32'hDEAD_BEE0);

        // Branch at 0x3008, low target bits forced to zero
        push_seq(32'h0000_2100, 3);
        redirect_at(32'h0000_3008, PC_SEL_BRANCH, 32'h0000_4444, 32'h0000_2101);

        // pc_selD ignored while stalled; 11 selects the jump target
        push_seq(32'h0000_5000, 3);
        wait_pc(32'h0000_2108, ok);
        stallD         = 1'b1;
        pc_selD        = PC_SEL_JUMP;
        jump_targetD   = 32'h0000_7000;
        branch_targetD = 32'h0000_6000;
        for (int k = 0; k < 2; k++) begin
            step();
            check("stall_sel_ignored", pcD, 32'h0000_2108);
        end
        stallD       = 1'b0;
        pc_selD      = 2'b11;
        jump_targetD = 32'h0000_5002;
        step();
        pc_selD = PC_SEL_PLUS4;

        // Jump near the top of the address space; PC wraps to 0
        push_seq(32'hFFFF_FFF8, 4);
        redirect_at(32'h0000_5008, PC_SEL_JUMP, 32'hFFFF_FFF9, 32'h0000_0000);

        // Asynchronous reset mid-stream with a full queue
        wait_pc(32'h0000_0008, ok);
        stallD = 1'b1;
        repeat (3) step();
        check("prereset_validD", 32'(validD), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check("async_validD", 32'(validD), 32'd0);
        check("async_instrD", instrD, NOP_INSTR);
        check("async_pcD", pcD, 32'd0);
        check("async_req_valid", 32'(imem_req_valid), 32'd0);
        check("sb_drained_pre_reset", 32'(exp_q.size()), 32'd0);
        stallD = 1'b0;
        repeat (2) @(posedge clk);

        // Restart from the reset PC
        @(negedge clk);
        push_seq(32'h0000_2000, 4);
        rst = 1'b1;
        #1;
        check("restart_req_addr", imem_req_addr, 32'h0000_2000);
        wait_pc(32'h0000_2010, ok);
        stallD = 1'b1;
        repeat (2) step();
        check("sb_drained_end", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/stage_fetch.md
Name: stage_fetch

Overview:
- Front stage of the 3-stage RISC-V pipeline.
- Issues instruction-memory requests and buffers returned words in a small in-order queue.
- Presents instrD/pcD/validD to the decode stage and accepts the decode stage's redirect (pc_selD plus branch/jump targets).
- Owns the architectural fetch PC, drops wrong-path responses after a redirect, and honours stallD.

Parameters:
- RESET_PC, 32'h0000_2000, first fetch address after reset.
- BUF_DEPTH, 2, instruction queue entries; also the maximum of (outstanding requests + queued entries); power of 2, ≥2.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- imem_req_valid  out  1  request valid.
- imem_req_ready  in  1  memory accepts the request this cycle.
- imem_req_addr  out  XLEN  word-aligned fetch address.
- imem_resp_valid  in  1  response word valid; responses return in request order.
- imem_resp_data  in  XLEN  instruction word.
- stallD  in  1  decode holds its current instruction.
- pc_selD  in  2  00 = PC+4, 01 = jump, 10 = branch taken, 11 = jump.
- branch_targetD  in  XLEN  branch target.
- jump_targetD  in  XLEN  jump target.
- instrD  out  XLEN  instruction at queue head; NOP_INSTR when not valid.
- pcD  out  XLEN  PC of instrD.
- validD  out  1  instrD/pcD hold a real instruction.

Behaviour:
- Reset values:
  - fetch_pc = resp_pc = RESET_PC.
  - Queue empty; outst = 0; drop_cnt = 0.
  - imem_req_valid = 0 while reset is asserted.
  - validD = 0, instrD = NOP_INSTR (32'h0000_0013), pcD = 0.
  - Reset mid-operation discards everything, including in-flight requests. Memory must be reset together with this block.
- Issue:
  - imem_req_valid = (outst + count < BUF_DEPTH) && !redir. imem_req_addr = fetch_pc.
  - On handshake: fetch_pc += 4, outst += 1.
  - imem_req_valid is a function of registered state and redir only, never of imem_req_ready.
- Response:
  - If drop_cnt != 0: discard the word, drop_cnt -= 1.
  - Otherwise push {resp_pc, imem_resp_data} and resp_pc += 4.
  - Every response decrements outst. imem_resp_valid with outst == 0 is ignored.
- Output and pop:
  - validD = (count != 0). instrD/pcD come from the queue head, read directly from the registered queue.
  - The head pops when validD && !stallD.
  - Push and pop in the same cycle are allowed. The credit rule guarantees no push into a full queue.
- Redirect:
  - redir = validD && !stallD && (pc_selD != 2'b00).
  - target = jump_targetD when pc_selD[0] = 1, else branch_targetD.
  - Next edge:
    - fetch_pc = resp_pc = target.
    - Queue flushed, including any word pushed this cycle.
    - drop_cnt = outst + drop_cnt − (imem_resp_valid ? 1 : 0).
  - No issue in the redirect cycle. The first target request is in cycle R+1.
  - With 1-cycle memory, the target is on instrD at R+3.
  - pc_selD is ignored when validD = 0 or stallD = 1.
- Latency: with imem_req_ready = 1 and 1-cycle memory, request at cycle N gives a response at N+1 and validD at N+2. Steady state is one instruction per cycle.
- Width rules: all PC arithmetic is modulo 2^XLEN and wraps silently. Bits [1:0] of targets are forced to 0 on redirect.
- Counters: outst and drop_cnt are clog2(BUF_DEPTH)+1 bits wide and never underflow.

Optional Feature:
- FETCH_PERF_CNT_EN defined:
  - Adds outputs perf_bubbles (32 bits): increments each cycle with !validD && !stallD.
  - Adds perf_redirects (32 bits): increments on each redir.
  - Both reset to 0 and saturate at all-ones.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- defines.v gains NOP_INSTR, PC_SEL_PLUS4 = 2'b00, PC_SEL_JUMP = 2'b01, PC_SEL_BRANCH = 2'b10, and the RESET_PC default. XLEN is already there.
- One sub-module, fetch_buffer:
  - Synchronous FIFO of width 2*XLEN, depth BUF_DEPTH.
  - Ports: push, pop, flush, head data, count. Flush has priority over push.

Test Plan:
- Reset release, ready = 1, 1-cycle memory returning addr^32'hA5A5_0000 → requests at 0x2000, 0x2004, …; validD first at cycle 2 with pcD = 0x2000; then 1 instr/cycle.
- stallD held 4 cycles with a full queue → imem_req_valid = 0 after 2 outstanding+queued; instrD/pcD stable; no word lost or duplicated after release.
- pc_selD = 01, jump_targetD = 0x3000 at pcD = 0x2004 with 2 in flight → both in-flight responses dropped; next validD shows pcD = 0x3000; no 0x2008 ever visible.
- pc_selD = 10, branch_targetD = 0x2100 in the same cycle as a response arrives → that response discarded; pcD = 0x2100 next; drop_cnt returns to 0.
- pc_selD = 01 while stallD = 1, then stallD = 0 → redirect only in the unstalled cycle; pc_selD = 11 selects jump_targetD.
- rst asserted mid-stream with the queue full → validD = 0 and instrD = NOP_INSTR immediately (asynchronously); after release, the fetch restarts at 0x2000.
